// File: rtl/multi_debounce.sv
// Purpose : multi-channel push-button conditioner: 2-flop sync + stable-time filter per channel.
// Latency : btn_level and press/release pulses change STABLE_CYCLES+2 edges after the raw pin changes.
// Backpressure: none; pulses are fire-and-forget single-cycle strobes.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset (clears every flop)
//   btn_raw       raw asynchronous button pins, polarity set by ACTIVE_LOW
//   btn_level     debounced level per channel, 1 = pressed
//   press_pulse   one-cycle strobe on debounced press (plus auto-repeat strobes when enabled)
//   release_pulse one-cycle strobe on debounced release
//   any_pressed   OR of btn_level
//
// Optional feature: define MULTI_DEBOUNCE_REPEAT_EN to add per-channel auto-repeat
// (first repeat REPEAT_DELAY cycles after the press, then every REPEAT_RATE cycles).

module multi_debounce #(
    parameter int CHANNELS      = 4,
    parameter int CNT_W         = 16,
    parameter int STABLE_CYCLES = 50000,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_RATE   = 5000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] btn_raw,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic                any_pressed
);

    // Elaboration-time parameter sanity checks.
    if (CHANNELS < 1) begin : g_bad_channels
        $error("multi_debounce: CHANNELS must be >= 1");
    end
    if (STABLE_CYCLES < 1 || longint'(STABLE_CYCLES) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_stable
        $error("multi_debounce: STABLE_CYCLES must be in 1 .. 2**CNT_W-1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
        $error("multi_debounce: REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [CHANNELS-1:0] p;       // normalised input, 1 = pressed
    logic [CHANNELS-1:0] s1;
    logic [CHANNELS-1:0] s2;
    logic [CNT_W-1:0]    cnt [CHANNELS];
    logic [CHANNELS-1:0] mature;  // this edge flips btn_level

    assign p           = btn_raw ^ {CHANNELS{ACTIVE_LOW}};
    assign any_pressed = |btn_level;

    always_comb begin
        mature = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            mature[i] = (s2[i] != btn_level[i]) && (cnt[i] == CNT_LAST);
        end
    end

`ifdef MULTI_DEBOUNCE_REPEAT_EN
    localparam int REP_W = CNT_W + 8;

    if (longint'(REPEAT_DELAY) > ((longint'(1) << REP_W) - 1) ||
        longint'(REPEAT_RATE)  > ((longint'(1) << REP_W) - 1)) begin : g_bad_rep_width
        $error("multi_debounce: REPEAT_DELAY/REPEAT_RATE must fit in CNT_W+8 bits");
    end

    localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);

    logic [REP_W-1:0]    rep_cnt [CHANNELS];
    logic [CHANNELS-1:0] rep_fast;  // 0: waiting out the initial delay, 1: repeating at REPEAT_RATE
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1            <= '0;
            s2            <= '0;
            btn_level     <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
`ifdef MULTI_DEBOUNCE_REPEAT_EN
            rep_fast <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                rep_cnt[i] <= '0;
            end
`endif
        end else begin
            s1            <= p;
            s2            <= s1;
            press_pulse   <= '0;
            release_pulse <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                // Stable-time filter: any return of s2 to the current level restarts the count.
                if (s2[i] == btn_level[i]) begin
                    cnt[i] <= '0;
                end else if (mature[i]) begin
                    cnt[i]           <= '0;
                    btn_level[i]     <= s2[i];
                    press_pulse[i]   <= s2[i];
                    release_pulse[i] <= ~s2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
`ifdef MULTI_DEBOUNCE_REPEAT_EN
                // Repeat timer only runs while the level is held. A release maturing on
                // this edge wins over a repeat strobe that would have landed here.
                if (!btn_level[i] || mature[i]) begin
                    rep_cnt[i]  <= '0;
                    rep_fast[i] <= 1'b0;
                end else if (rep_cnt[i] == (rep_fast[i] ? RATE_LAST : DELAY_LAST)) begin
                    rep_cnt[i]     <= '0;
                    rep_fast[i]    <= 1'b1;
                    press_pulse[i] <= 1'b1;
                end else begin
                    rep_cnt[i] <= rep_cnt[i] + 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_multi_debounce.sv
// Purpose : scoreboard bench for multi_debounce (4 channels, STABLE_CYCLES=4, active-low pins).
// Latency : expected pulses are queued with their absolute edge number (drive edge + 6).
// Backpressure: n/a; a negedge monitor pops one expectation per observed pulse cycle.

module tb_multi_debounce;

    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] btn_raw;
    logic [CH-1:0] btn_level;
    logic [CH-1:0] press_pulse;
    logic [CH-1:0] release_pulse;
    logic          any_pressed;

    multi_debounce #(
        .CHANNELS      (CH),
        .CNT_W         (4),
        .STABLE_CYCLES (4),
        .ACTIVE_LOW    (1'b1),
        .REPEAT_DELAY  (10),
        .REPEAT_RATE   (5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .any_pressed   (any_pressed)
    );

    always #5 clk = ~clk;

    int cyc = 0;  // number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            at;
        logic [CH-1:0] press;
        logic [CH-1:0] rel;
        logic [CH-1:0] level;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int at, input logic [CH-1:0] pr, input logic [CH-1:0] rl,
                        input logic [CH-1:0] lv);
        exp_t e;
        e.at = at; e.press = pr; e.rel = rl; e.level = lv;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every cycle carrying a pulse must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if ((press_pulse | release_pulse) != '0) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: press=%b release=%b at edge %0d, none expected",
                         press_pulse, release_pulse, cyc);
            end else begin
                e = sb.pop_front();
                chk("pulse_edge", cyc, e.at);
                chk("press_pulse", press_pulse, e.press);
                chk("release_pulse", release_pulse, e.rel);
                chk("btn_level", btn_level, e.level);
                chk("any_pressed", any_pressed, (e.level != '0));
            end
        end else if (sb.size() != 0 && sb[0].at < cyc) begin
            e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missed_pulse: nothing seen, expected press=%b release=%b at edge %0d",
                     e.press, e.rel, e.at);
        end
    end

    initial begin
        int t0;
        reset   = 1'b0;
        btn_raw = 4'b0000;  // all buttons held through reset

        // 1. Outputs stay cleared during reset, held buttons become a press after release.
        repeat (10) begin
            @(negedge clk);
            chk("reset_level", btn_level, 4'b0000);
            chk("reset_press", press_pulse, 4'b0000);
            chk("reset_release", release_pulse, 4'b0000);
            chk("reset_any", any_pressed, 1'b0);
        end
        reset = 1'b1;
        push(cyc + 6, 4'b1111, 4'b0000, 4'b1111);
        wait_cyc(10);
        btn_raw = 4'b1111;
        push(cyc + 6, 4'b0000, 4'b1111, 4'b0000);
        wait_cyc(10);

        // 2. Clean press and release on ch0.
        btn_raw[0] = 1'b0;
        push(cyc + 6, 4'b0001, 4'b0000, 4'b0001);
        wait_cyc(10);
        btn_raw[0] = 1'b1;
        push(cyc + 6, 4'b0000, 4'b0001, 4'b0000);
        wait_cyc(10);

        // 3. Bounce on ch1: toggle every 2 cycles, then settle low.
        for (int k = 0; k < 10; k++) begin
            btn_raw[1] = ~btn_raw[1];
            wait_cyc(2);
        end
        btn_raw[1] = 1'b0;
        push(cyc + 6, 4'b0010, 4'b0000, 4'b0010);
        wait_cyc(10);
        btn_raw[1] = 1'b1;
        push(cyc + 6, 4'b0000, 4'b0010, 4'b0000);
        wait_cyc(10);

        // 4. 3-cycle glitch on ch2: one short of the stable time, so no output change.
        btn_raw[2] = 1'b0;
        wait_cyc(3);
        btn_raw[2] = 1'b1;
        wait_cyc(10);
        chk("glitch_level", btn_level, 4'b0000);

        // 5. Reset while ch3 is mid-count; press re-qualifies from reset release.
        btn_raw[3] = 1'b0;
        wait_cyc(4);
        reset = 1'b0;
        wait_cyc(1);
        chk("midreset_level", btn_level, 4'b0000);
        chk("midreset_any", any_pressed, 1'b0);
        wait_cyc(1);
        reset = 1'b1;
        push(cyc + 6, 4'b1000, 4'b0000, 4'b1000);
        wait_cyc(10);
        btn_raw[3] = 1'b1;
        push(cyc + 6, 4'b0000, 4'b1000, 4'b0000);
        wait_cyc(10);

        // 6. Long hold on ch0; release lands exactly on a would-be repeat edge (t0+30).
        btn_raw[0] = 1'b0;
        t0 = cyc + 6;
        push(t0, 4'b0001, 4'b0000, 4'b0001);
`ifdef MULTI_DEBOUNCE_REPEAT_EN
        push(t0 + 10, 4'b0001, 4'b0000, 4'b0001);
        push(t0 + 15, 4'b0001, 4'b0000, 4'b0001);
        push(t0 + 20, 4'b0001, 4'b0000, 4'b0001);
        push(t0 + 25, 4'b0001, 4'b0000, 4'b0001);
`endif
        wait_cyc(30);
        btn_raw[0] = 1'b1;
        push(t0 + 30, 4'b0000, 4'b0001, 4'b0000);
        wait_cyc(14);

        chk("scoreboard_drained", sb.size(), 0);
        chk("final_level", btn_level, 4'b0000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_debounce.md
Name: multi_debounce

Overview:
Parametrised multi-channel push-button conditioner for the vending machine front panel (coin and product-select keys).
- Per channel: 2-flop synchroniser, then a stable-time counter filter.
- Outputs per channel: a clean debounced level plus single-cycle press and release pulses.
- Replaces per-button 2-flop edge detectors, which pass contact bounce through as multiple pulses.

Parameters:
CHANNELS, 4, number of independent button channels (>=1).
CNT_W, 16, width of each stable-time counter.
STABLE_CYCLES, 50000, consecutive clk cycles a synchronised input must differ from the current level before the level flips; legal range 1 to 2^CNT_W-1, otherwise elaboration error.
ACTIVE_LOW, 1, 1: raw input low means pressed; 0: raw input high means pressed.
REPEAT_DELAY, 25000000, cycles from press pulse to first auto-repeat pulse (used only with MULTI_DEBOUNCE_REPEAT_EN).
REPEAT_RATE, 5000000, cycles between subsequent auto-repeat pulses (used only with MULTI_DEBOUNCE_REPEAT_EN).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
btn_raw  input  CHANNELS  raw asynchronous button pins.
btn_level  output  CHANNELS  debounced level, 1 = pressed.
press_pulse  output  CHANNELS  one-cycle pulse on debounced press (and auto-repeat when enabled).
release_pulse  output  CHANNELS  one-cycle pulse on debounced release.
any_pressed  output  1  OR of btn_level.

Behaviour:
- Clock, reset and output registers:
  - Clock is clk; reset is reset, asynchronous, active-low.
  - While reset=0, all flops clear: sync flops = released, counters = 0, btn_level = 0, press_pulse = 0, release_pulse = 0, so any_pressed = 0.
- Input path and filter, per channel, fully independent:
  - Normalise: p = btn_raw XOR ACTIVE_LOW, so 1 = pressed.
  - Synchronise: s1 <= p, s2 <= s1.
  - Each edge, if s2 == btn_level: cnt <= 0.
  - Otherwise, if cnt == STABLE_CYCLES-1: btn_level <= s2, cnt <= 0, and the matching pulse is registered on the same edge.
  - Otherwise: cnt <= cnt+1.
- Latency: the edge that first samples the new raw value into s1 is edge 1. btn_level and the pulse change on edge STABLE_CYCLES+2, provided the input is held throughout.
- Glitch and bounce: any reversion of s2 to btn_level before the count completes clears cnt. Disturbances shorter than STABLE_CYCLES cycles produce no output change.
- Pulses:
  - Registered outputs, exactly one cycle wide.
  - press_pulse coincides with the btn_level 0->1 edge; release_pulse coincides with the 1->0 edge.
  - press_pulse and release_pulse are never both high on one channel.
- Simultaneous events: multiple channels maturing on the same edge pulse on that same edge; there is no arbitration.
- Reset mid-operation:
  - A partially counted transition is discarded.
  - A button still held when reset deasserts is treated as a new press: press_pulse fires STABLE_CYCLES+2 edges after reset release.
- Counter never wraps: it is bounded by STABLE_CYCLES-1.
- any_pressed is combinational from the btn_level registers only.

Optional Feature:
Macro MULTI_DEBOUNCE_REPEAT_EN.
- Defined:
  - Each channel has a repeat counter, cleared while btn_level=0.
  - After a press pulse, press_pulse fires again REPEAT_DELAY cycles later, then every REPEAT_RATE cycles while btn_level stays 1.
  - On release: repeat stops immediately; a repeat pulse due on the release edge is suppressed; release_pulse is unaffected.
  - REPEAT_DELAY and REPEAT_RATE must be >=1 and fit in CNT_W+8 bits.
- Undefined: no repeat logic is synthesised; exactly one press_pulse per debounced press.

Test Plan:
All cases use CHANNELS=4, STABLE_CYCLES=4, ACTIVE_LOW=1, CNT_W=4.
1. Reset with held buttons: hold btn_raw=4'b0000 with reset=0 for 10 cycles, then release reset -> all outputs 0 during reset; press_pulse=4'b1111 for one cycle and btn_level=4'b1111 on the 6th edge after release; any_pressed=1.
2. Clean press/release, ch0: btn_raw[0] 1->0 -> press_pulse[0] high only on edge 6. Later 0->1 -> release_pulse[0] on edge 6; btn_level[0] returns to 0.
3. Bounce, ch1: btn_raw[1] toggles every 2 cycles for 20 cycles, then stays 0 -> no pulses during bounce; exactly one press_pulse[1], 6 edges after the final transition.
4. Glitch, ch2: 3-cycle low pulse on btn_raw[2] -> btn_level[2], press_pulse[2] and release_pulse[2] stay 0.
5. Reset mid-count: btn_raw[3] goes low; assert reset after edge 4, release 2 cycles later with the input still low -> no pulse before reset; press_pulse[3] on the 6th edge after release.
6. Repeat, macro defined, REPEAT_DELAY=10, REPEAT_RATE=5: hold ch0 for 30 cycles -> press_pulse[0] at t0, t0+10, t0+15, t0+20, t0+25. Same stimulus with the macro undefined -> only t0.
